// File: rtl/adc_scan_scheduler_if.sv
// ADC pin bus and UART request handshake seen by adc_scan_scheduler.
// master = scheduler side, slave = board pins / UART side.
interface adc_scan_scheduler_if;
   logic       adc_clock;
   logic       ale;
   logic       start;
   logic       oe;
   logic [2:0] address;
   logic       eoc;
   logic [7:0] adc_data;
   logic [7:0] tx_data;
   logic       tx_send;
   logic       tx_ready;

   modport master (
      output adc_clock, ale, start, oe, address, tx_data, tx_send,
      input  eoc, adc_data, tx_ready
   );

   modport slave (
      input  adc_clock, ale, start, oe, address, tx_data, tx_send,
      output eoc, adc_data, tx_ready
   );
endinterface

// File: rtl/adc_scan_scheduler.sv
// Round-robin ADC0808/0809 scan scheduler feeding a level-handshake UART transmitter.
// Optional macro CHANNEL_TAG_EN: send a tag byte {4'hA,1'b0,address} ahead of each sample.
module adc_scan_scheduler #(
   parameter int ADC_CLK_DIV  = 50,
   parameter int SETUP_CYCLES = 4,
   parameter int START_CYCLES = 8,
   parameter int OE_CYCLES    = 4,
   parameter int EOC_TIMEOUT  = 20000
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        scan_enable,
   input  logic [7:0]                  channel_mask,
   adc_scan_scheduler_if.master        bus,
   output logic                        busy,
   output logic                        sample_valid,
   output logic [2:0]                  sample_channel,
   output logic                        timeout_err
);

   localparam logic [3:0] IDLE    = 4'd0;
   localparam logic [3:0] SELECT  = 4'd1;
   localparam logic [3:0] ADDR    = 4'd2;
   localparam logic [3:0] START_P = 4'd3;
   localparam logic [3:0] WAIT_LO = 4'd4;
   localparam logic [3:0] WAIT_HI = 4'd5;
   localparam logic [3:0] READ    = 4'd6;
   localparam logic [3:0] TX_REQ  = 4'd7;
   localparam logic [3:0] TX_ACC  = 4'd8;
   localparam logic [3:0] TX_DONE = 4'd9;

   localparam int         DIV_W      = $clog2(ADC_CLK_DIV + 1);
   localparam logic [19:0] SETUP_LAST = 20'(SETUP_CYCLES - 1);
   localparam logic [19:0] START_LAST = 20'(START_CYCLES - 1);
   localparam logic [19:0] OE_LAST    = 20'(OE_CYCLES - 1);
   localparam logic [19:0] TMO_LAST   = 20'(EOC_TIMEOUT - 1);

   logic [3:0]       state;
   logic [19:0]      cnt;
   logic [2:0]       last_ch;
   logic [2:0]       next_ch;
   logic [2:0]       cand;
   logic             found;
   logic [DIV_W-1:0] div_cnt;
   logic             eoc_p0;
   logic             eoc_p1;
`ifdef CHANNEL_TAG_EN
   logic [7:0]       data_buf;
   logic             tag_phase;
`endif

   assign busy = (state != IDLE);

   // Free-running ADC conversion clock, independent of the scan state
   always_ff @(posedge clock) begin
      if (reset) begin
         div_cnt       <= '0;
         bus.adc_clock <= 1'b0;
      end else if (div_cnt == DIV_W'(ADC_CLK_DIV - 1)) begin
         div_cnt       <= '0;
         bus.adc_clock <= ~bus.adc_clock;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   // eoc synchronizer stage p0 -> p1
   always_ff @(posedge clock) begin
      if (reset) begin
         eoc_p0 <= 1'b0;
         eoc_p1 <= 1'b0;
      end else begin
         eoc_p0 <= bus.eoc;
         eoc_p1 <= eoc_p0;
      end
   end

   // Next enabled channel strictly after last_ch; i == 8 lets a lone channel reselect itself
   always_comb begin
      next_ch = last_ch;
      found   = 1'b0;
      cand    = last_ch;
      for (int i = 1; i <= 8; i++) begin
         cand = last_ch + 3'(i);
         if (!found && channel_mask[cand]) begin
            next_ch = cand;
            found   = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= IDLE;
         cnt            <= '0;
         last_ch        <= 3'd7;
         bus.ale        <= 1'b0;
         bus.start      <= 1'b0;
         bus.oe         <= 1'b0;
         bus.address    <= 3'd0;
         bus.tx_data    <= 8'd0;
         bus.tx_send    <= 1'b0;
         sample_valid   <= 1'b0;
         sample_channel <= 3'd0;
         timeout_err    <= 1'b0;
`ifdef CHANNEL_TAG_EN
         data_buf       <= 8'd0;
         tag_phase      <= 1'b0;
`endif
      end else begin
         sample_valid <= 1'b0;
         timeout_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (scan_enable && (channel_mask != 8'd0)) state <= SELECT;
            end
            SELECT: begin
               if (!scan_enable || (channel_mask == 8'd0)) begin
                  state <= IDLE;
               end else begin
                  bus.address <= next_ch;
                  bus.ale     <= 1'b1;
                  cnt         <= '0;
                  state       <= ADDR;
               end
            end
            ADDR: begin
               if (cnt == SETUP_LAST) begin
                  cnt       <= '0;
                  bus.start <= 1'b1;
                  state     <= START_P;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            START_P: begin
               if (cnt == START_LAST) begin
                  cnt       <= '0;
                  bus.ale   <= 1'b0;
                  bus.start <= 1'b0;
                  state     <= WAIT_LO;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            // Timeout wins over a same-cycle eoc edge so the pulse time is exact
            WAIT_LO, WAIT_HI: begin
               if (cnt == TMO_LAST) begin
                  timeout_err <= 1'b1;
                  last_ch     <= bus.address;
                  state       <= SELECT;
               end else if (state == WAIT_LO) begin
                  cnt <= cnt + 1'b1;
                  if (!eoc_p1) state <= WAIT_HI;
               end else if (eoc_p1) begin
                  cnt    <= '0;
                  bus.oe <= 1'b1;
                  state  <= READ;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            READ: begin
               if (cnt == OE_LAST) begin
                  bus.oe         <= 1'b0;
                  sample_valid   <= 1'b1;
                  sample_channel <= bus.address;
`ifdef CHANNEL_TAG_EN
                  data_buf       <= bus.adc_data;
                  bus.tx_data    <= {4'hA, 1'b0, bus.address};
                  tag_phase      <= 1'b1;
`else
                  bus.tx_data    <= bus.adc_data;
`endif
                  state          <= TX_REQ;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            TX_REQ: begin
               if (bus.tx_ready) begin
                  bus.tx_send <= 1'b1;
                  state       <= TX_ACC;
               end
            end
            TX_ACC: begin
               if (!bus.tx_ready) begin
                  bus.tx_send <= 1'b0;
                  state       <= TX_DONE;
               end
            end
            TX_DONE: begin
               if (bus.tx_ready) begin
`ifdef CHANNEL_TAG_EN
                  if (tag_phase) begin
                     tag_phase   <= 1'b0;
                     bus.tx_data <= data_buf;
                     state       <= TX_REQ;
                  end else begin
                     last_ch <= bus.address;
                     state   <= SELECT;
                  end
`else
                  last_ch <= bus.address;
                  state   <= SELECT;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Scoreboard bench for adc_scan_scheduler with behavioural ADC0808 and UART models.
module tb_adc_scan_scheduler;
   localparam int ADC_CLK_DIV  = 5;
   localparam int SETUP_CYCLES = 4;
   localparam int START_CYCLES = 8;
   localparam int OE_CYCLES    = 4;
   localparam int EOC_TIMEOUT  = 300;
   localparam int CONV         = 30;
   localparam int UART_BUSY    = 5;
   localparam int LIM          = 3000;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       scan_enable = 1'b0;
   logic [7:0] channel_mask = 8'd0;
   logic       busy, sample_valid, timeout_err;
   logic [2:0] sample_channel;
   logic       eoc_stuck = 1'b0;

   int errors = 0;
   int checks = 0;
   logic [7:0] exp_tx[$];
   logic [2:0] exp_addr[$];
   logic [2:0] exp_samp[$];
   int start_count = 0;
   int timeout_count = 0;

   adc_scan_scheduler_if bus ();

   adc_scan_scheduler #(
      .ADC_CLK_DIV(ADC_CLK_DIV), .SETUP_CYCLES(SETUP_CYCLES), .START_CYCLES(START_CYCLES),
      .OE_CYCLES(OE_CYCLES), .EOC_TIMEOUT(EOC_TIMEOUT)
   ) dut (
      .clock(clock), .reset(reset), .scan_enable(scan_enable), .channel_mask(channel_mask),
      .bus(bus), .busy(busy), .sample_valid(sample_valid),
      .sample_channel(sample_channel), .timeout_err(timeout_err)
   );

   always #5 clock = ~clock;

   // ADC data bus: channel n converts to 0x30+n while OE is asserted
   assign bus.adc_data = bus.oe ? (8'h30 + {5'd0, bus.address}) : 8'hFF;

   function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endfunction

   task automatic push_sample(input logic [2:0] ch);
`ifdef CHANNEL_TAG_EN
      exp_tx.push_back({4'hA, 1'b0, ch});
      exp_addr.push_back(ch);
`endif
      exp_tx.push_back(8'h30 + {5'd0, ch});
      exp_addr.push_back(ch);
      exp_samp.push_back(ch);
   endtask

   task automatic wait_empty(input string nm);
      int n = 0;
      while (exp_tx.size() != 0 && n < LIM) begin
         @(negedge clock);
         n++;
      end
      check(nm, exp_tx.size(), 0);
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while (busy && n < LIM) begin
         @(negedge clock);
         n++;
      end
      check(nm, busy, 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      scan_enable = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
   endtask

   // ADC model: eoc falls while START is high, rises CONV cycles after START falls
   initial begin : adc_model
      int conv;
      conv = 0;
      bus.eoc = 1'b1;
      forever begin
         @(negedge clock);
         if (bus.start && !eoc_stuck) begin
            bus.eoc = 1'b0;
            conv = CONV;
         end else if (!bus.eoc && !bus.start) begin
            if (conv == 0) bus.eoc = 1'b1;
            else conv--;
         end
      end
   end

   // UART model: accepts 3 cycles after a request, stays busy UART_BUSY cycles
   initial begin : uart_model
      bus.tx_ready = 1'b1;
      forever begin
         @(negedge clock);
         if (bus.tx_send && bus.tx_ready) begin
            repeat (2) @(negedge clock);
            bus.tx_ready = 1'b0;
            repeat (UART_BUSY) @(negedge clock);
            bus.tx_ready = 1'b1;
         end
      end
   end

   logic prev_send = 1'b0, prev_ready = 1'b1, prev_start = 1'b0, prev_ale = 1'b0;
   int start_len = 0, ale_len = 0, since_fall = 0;

   always @(negedge clock) begin : monitor
      if (bus.tx_send && !prev_send) begin
         check("send_while_not_ready", prev_ready, 1);
         if (exp_tx.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected: got byte %0h required none", bus.tx_data);
         end else begin
            check("tx_data", bus.tx_data, exp_tx.pop_front());
            check("tx_address", bus.address, exp_addr.pop_front());
         end
      end
      if (sample_valid) begin
         if (exp_samp.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sample_unexpected: got channel %0d required none", sample_channel);
         end else begin
            check("sample_channel", sample_channel, exp_samp.pop_front());
         end
      end
      if (bus.start && !prev_start) start_count++;
      if (reset) begin
         start_len = 0;
         ale_len = 0;
      end else begin
         if (bus.start) start_len++;
         else if (prev_start) begin
            check("start_width", start_len, START_CYCLES);
            start_len = 0;
         end
         if (bus.ale) ale_len++;
         else if (prev_ale) begin
            check("ale_width", ale_len, SETUP_CYCLES + START_CYCLES);
            ale_len = 0;
         end
      end
      if (!bus.start && prev_start) since_fall = 0;
      else since_fall++;
      if (timeout_err) begin
         check("timeout_delay", since_fall, EOC_TIMEOUT);
         timeout_count++;
      end
      prev_send  = bus.tx_send;
      prev_ready = bus.tx_ready;
      prev_start = bus.start;
      prev_ale   = bus.ale;
   end

   initial begin : stimulus
      logic ref_clk;
      int n, s0, t0;
      repeat (3) @(negedge clock);
      check("rst_adc_clock", bus.adc_clock, 0);
      check("rst_ale", bus.ale, 0);
      check("rst_start", bus.start, 0);
      check("rst_oe", bus.oe, 0);
      check("rst_address", bus.address, 0);
      check("rst_tx_data", bus.tx_data, 0);
      check("rst_tx_send", bus.tx_send, 0);
      check("rst_busy", busy, 0);
      check("rst_sample_valid", sample_valid, 0);
      check("rst_sample_channel", sample_channel, 0);
      check("rst_timeout_err", timeout_err, 0);
      reset = 1'b0;

      // adc_clock divider: first toggle and full half-period
      n = 0;
      while (!bus.adc_clock && n < 100) begin
         @(negedge clock);
         n++;
      end
      check("adc_clk_first_toggle", n, ADC_CLK_DIV);
      ref_clk = bus.adc_clock;
      n = 0;
      while (bus.adc_clock == ref_clk && n < 100) begin
         @(negedge clock);
         n++;
      end
      check("adc_clk_half_period", n, ADC_CLK_DIV);

      // Two-channel round robin
      channel_mask = 8'b0000_0101;
      push_sample(3'd0); push_sample(3'd2); push_sample(3'd0); push_sample(3'd2);
      scan_enable = 1'b1;
      wait_empty("t1_drain");
      scan_enable = 1'b0;
      wait_idle("t1_idle");
      check("t1_samples_left", exp_samp.size(), 0);

      // Single channel 7
      do_reset();
      s0 = start_count;
      channel_mask = 8'h80;
      push_sample(3'd7); push_sample(3'd7);
      scan_enable = 1'b1;
      wait_empty("t2_drain");
      scan_enable = 1'b0;
      wait_idle("t2_idle");
      check("t2_start_pulses", start_count - s0, 2);

      // EOC timeout on ch1, scheduler moves on to ch2
      do_reset();
      t0 = timeout_count;
      channel_mask = 8'h06;
      eoc_stuck = 1'b1;
      push_sample(3'd2);
      scan_enable = 1'b1;
      n = 0;
      while (!timeout_err && n < LIM) begin
         @(negedge clock);
         n++;
      end
      check("t3_timeout_seen", timeout_err, 1);
      eoc_stuck = 1'b0;
      wait_empty("t3_drain");
      scan_enable = 1'b0;
      wait_idle("t3_idle");
      check("t3_timeout_pulses", timeout_count - t0, 1);
      check("t3_last_address", bus.address, 2);

      // scan_enable falls while waiting for eoc on ch3
      do_reset();
      channel_mask = 8'h08;
      push_sample(3'd3);
      scan_enable = 1'b1;
      n = 0;
      while (!(!bus.eoc && !bus.start) && n < LIM) begin
         @(negedge clock);
         n++;
      end
      check("t4_eoc_low", bus.eoc, 0);
      repeat (4) @(negedge clock);
      scan_enable = 1'b0;
      wait_empty("t4_drain");
      wait_idle("t4_idle");
      s0 = start_count;
      repeat (200) @(negedge clock);
      check("t4_no_restart", start_count - s0, 0);
      check("t4_busy_stays_low", busy, 0);

      // reset while tx_send is high
      do_reset();
      channel_mask = 8'h0C;
      push_sample(3'd2);
      scan_enable = 1'b1;
      n = 0;
      while (!bus.tx_send && n < LIM) begin
         @(negedge clock);
         n++;
      end
      check("t5_tx_send_seen", bus.tx_send, 1);
      reset = 1'b1;
      @(posedge clock);
      #1;
      check("t5_rst_tx_send", bus.tx_send, 0);
      check("t5_rst_busy", busy, 0);
      check("t5_rst_address", bus.address, 0);
      exp_tx.delete();
      exp_addr.delete();
      exp_samp.delete();
      push_sample(3'd2);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      wait_empty("t5_drain");
      scan_enable = 1'b0;
      wait_idle("t5_idle");

`ifdef CHANNEL_TAG_EN
      // Tagged stream on ch1
      do_reset();
      channel_mask = 8'h02;
      push_sample(3'd1); push_sample(3'd1);
      scan_enable = 1'b1;
      wait_empty("t6_drain");
      scan_enable = 1'b0;
      wait_idle("t6_idle");
`endif

      repeat (5) @(negedge clock);
      check("final_samples_left", exp_samp.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
